// File: rtl/apb_mbox_slave_pkg.sv
// Shared definitions for the APB mailbox responder: register offsets,
// CTRL bit positions, STATUS layout and the APB FSM state type.
package apb_mbox_slave_pkg;

  localparam logic [1:0] MBOX_REG_DATA   = 2'd0;
  localparam logic [1:0] MBOX_REG_STATUS = 2'd1;
  localparam logic [1:0] MBOX_REG_CTRL   = 2'd2;
  localparam logic [1:0] MBOX_REG_RSVD   = 2'd3;

  localparam int unsigned MBOX_CTRL_FLUSH  = 0;
  localparam int unsigned MBOX_CTRL_CLRFLG = 1;

  // STATUS flag positions, relative to the top of the count field
  localparam int unsigned MBOX_STAT_EMPTY = 0;
  localparam int unsigned MBOX_STAT_FULL  = 1;
  localparam int unsigned MBOX_STAT_OVF   = 2;
  localparam int unsigned MBOX_STAT_UDF   = 3;

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } apb_state_e;

  function automatic int unsigned mbox_cw(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/apb_mbox_slave_fifo.sv
// Synchronous mailbox FIFO with flush; pushes while full and pops while
// empty are ignored here and flagged by the register block.
module mbox_fifo #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          flush,
  input  logic [DATA_WIDTH-1:0]         din,
  output logic [DATA_WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          full,
  output logic                          empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/apb_mbox_slave.sv
// APB responder exposing a mailbox FIFO (DATA push/pop), STATUS, CTRL,
// sticky overflow/underflow flags and fixed programmable wait states.
module apb_mbox_slave
  import apb_mbox_slave_pkg::*;
#(
  parameter int unsigned BUS_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BUS_WIDTH-1:0]  S_PADDR,
  input  logic                  S_PWRITE,
  input  logic                  S_PSELx,
  input  logic                  S_PENABLE,
  input  logic [DATA_WIDTH-1:0] S_PWDATA,
  output logic [DATA_WIDTH-1:0] S_PRDATA,
  output logic                  S_PREADY,
  output logic                  mbox_nempty
);

  localparam int unsigned CW = mbox_cw(DEPTH);
  localparam logic [3:0]  WS = 4'(WAIT_STATES);

  apb_state_e            state;
  logic [3:0]            wcnt;
  logic                  ovf;
  logic                  udf;
  logic [1:0]            reg_sel;
  logic                  push;
  logic                  pop;
  logic                  flush;
  logic                  clr;
  logic                  nempty_next;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic [DATA_WIDTH-1:0] status;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  unused_addr;

  assign reg_sel     = S_PADDR[1:0];
  assign unused_addr = ^S_PADDR[BUS_WIDTH-1:2];

  assign S_PREADY = (state == ST_ACCESS) && S_PSELx && S_PENABLE && (wcnt == '0);

  // Side effects fire only on the committing edge of a transfer.
  always_comb begin
    push  = 1'b0;
    pop   = 1'b0;
    flush = 1'b0;
    clr   = 1'b0;
    if (S_PREADY) begin
      case (reg_sel)
        MBOX_REG_DATA: begin
          push = S_PWRITE;
          pop  = !S_PWRITE;
        end
        MBOX_REG_CTRL: begin
          flush = S_PWRITE && S_PWDATA[MBOX_CTRL_FLUSH];
          clr   = S_PWRITE && S_PWDATA[MBOX_CTRL_CLRFLG];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    if (flush)                nempty_next = 1'b0;
    else if (push && !full)   nempty_next = 1'b1;
    else if (pop && !empty)   nempty_next = (count != CW'(1));
    else                      nempty_next = !empty;
  end

  always_comb begin
    status                        = '0;
    status[CW-1:0]                = count;
    status[CW + MBOX_STAT_EMPTY]  = empty;
    status[CW + MBOX_STAT_FULL]   = full;
    status[CW + MBOX_STAT_OVF]    = ovf;
    status[CW + MBOX_STAT_UDF]    = udf;
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      MBOX_REG_DATA:   rdata = empty ? '0 : fifo_dout;
      MBOX_REG_STATUS: rdata = status;
      default:         rdata = '0;
    endcase
  end

  assign S_PRDATA = S_PREADY ? rdata : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      wcnt        <= '0;
      ovf         <= 1'b0;
      udf         <= 1'b0;
      mbox_nempty <= 1'b0;
    end else begin
      mbox_nempty <= nempty_next;
      if (clr) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end else begin
        if (push && full)  ovf <= 1'b1;
        if (pop && empty)  udf <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (S_PSELx && !S_PENABLE) begin
            state <= ST_ACCESS;
            wcnt  <= WS;
          end
        end
        ST_ACCESS: begin
          // Dropping PSELx mid-transfer aborts with no side effect.
          if (!S_PSELx) begin
            state <= ST_IDLE;
          end else if (S_PENABLE) begin
            if (wcnt == '0) state <= ST_IDLE;
            else            wcnt  <= wcnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mbox_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (S_PWDATA),
    .dout  (fifo_dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_apb_mbox_slave.sv
// Directed bench: one responder with no wait states, one with three,
// sharing address/data/enable lines and selected by separate PSELx.
module tb_apb_mbox_slave;

  logic        clk;
  logic        reset;
  logic [15:0] paddr;
  logic        pwrite;
  logic        penable;
  logic [15:0] pwdata;
  logic        psel0;
  logic        psel3;
  logic [15:0] prd0;
  logic [15:0] prd3;
  logic        rdy0;
  logic        rdy3;
  logic        ne0;
  logic        ne3;

  int checks;
  int failures;

  apb_mbox_slave #(
    .BUS_WIDTH(16), .DATA_WIDTH(16), .DEPTH(8), .WAIT_STATES(0)
  ) dut0 (
    .clk(clk), .reset(reset), .S_PADDR(paddr), .S_PWRITE(pwrite),
    .S_PSELx(psel0), .S_PENABLE(penable), .S_PWDATA(pwdata),
    .S_PRDATA(prd0), .S_PREADY(rdy0), .mbox_nempty(ne0)
  );

  apb_mbox_slave #(
    .BUS_WIDTH(16), .DATA_WIDTH(16), .DEPTH(8), .WAIT_STATES(3)
  ) dut3 (
    .clk(clk), .reset(reset), .S_PADDR(paddr), .S_PWRITE(pwrite),
    .S_PSELx(psel3), .S_PENABLE(penable), .S_PWDATA(pwdata),
    .S_PRDATA(prd3), .S_PREADY(rdy3), .mbox_nempty(ne3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Caller must be 1ns after a rising edge; returns 1ns after the commit edge.
  task automatic xfer(input bit d3, input logic [1:0] a, input bit wr,
                      input logic [15:0] wd, output logic [15:0] rd,
                      output int waits, output bit ne_w);
    bit got;
    paddr   = {14'b0, a};
    pwrite  = wr;
    pwdata  = wd;
    psel0   = !d3;
    psel3   = d3;
    penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0;
    ne_w  = 1'b0;
    rd    = '0;
    got   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (d3 ? rdy3 : rdy0) begin
        rd  = d3 ? prd3 : prd0;
        got = 1'b1;
        break;
      end
      waits++;
      ne_w = ne_w | (d3 ? ne3 : ne0);
      @(posedge clk); #1;
    end
    chk("pready_timeout", {31'b0, got}, 32'd1);
    @(posedge clk); #1;
    psel0   = 1'b0;
    psel3   = 1'b0;
    penable = 1'b0;
  endtask

  task automatic wr(input bit d3, input logic [1:0] a, input logic [15:0] d);
    logic [15:0] r;
    int          w;
    bit          n;
    xfer(d3, a, 1'b1, d, r, w, n);
  endtask

  task automatic rdchk(input bit d3, input logic [1:0] a, input logic [15:0] exp, input string tag);
    logic [15:0] r;
    int          w;
    bit          n;
    xfer(d3, a, 1'b0, 16'h0, r, w, n);
    chk(tag, {16'b0, r}, {16'b0, exp});
  endtask

  initial begin
    logic [15:0] r;
    int          w;
    bit          n;
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    paddr    = '0;
    pwrite   = 1'b0;
    penable  = 1'b0;
    pwdata   = '0;
    psel0    = 1'b0;
    psel3    = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_pready", {31'b0, rdy0}, 32'd0);
    chk("rst_prdata", {16'b0, prd0}, 32'd0);
    chk("rst_nempty", {31'b0, ne0}, 32'd0);
    chk("rst_pready_ws3", {31'b0, rdy3}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // STATUS after reset: empty only, completes in the first access cycle
    xfer(1'b0, 2'd1, 1'b0, 16'h0, r, w, n);
    chk("status_reset", {16'b0, r}, 32'h0010);
    chk("status_reset_waits", w, 0);
    chk("nempty_reset", {31'b0, ne0}, 32'd0);

    wr(1'b0, 2'd0, 16'h1111);
    wr(1'b0, 2'd0, 16'h2222);
    wr(1'b0, 2'd0, 16'h3333);
    rdchk(1'b0, 2'd1, 16'h0003, "status_cnt3");
    chk("nempty_cnt3", {31'b0, ne0}, 32'd1);
    rdchk(1'b0, 2'd0, 16'h1111, "pop_1111");
    rdchk(1'b0, 2'd0, 16'h2222, "pop_2222");
    rdchk(1'b0, 2'd0, 16'h3333, "pop_3333");
    rdchk(1'b0, 2'd1, 16'h0010, "status_drained");
    chk("nempty_drained", {31'b0, ne0}, 32'd0);

    // Register map corners: STATUS write ignored, CTRL and reserved read 0
    wr(1'b0, 2'd1, 16'hFFFF);
    rdchk(1'b0, 2'd1, 16'h0010, "status_write_ignored");
    rdchk(1'b0, 2'd2, 16'h0000, "ctrl_reads_zero");
    rdchk(1'b0, 2'd3, 16'h0000, "rsvd_reads_zero");

    // Overflow then underflow
    for (int i = 0; i < 9; i++) wr(1'b0, 2'd0, 16'h00A0 + 16'(i));
    rdchk(1'b0, 2'd1, 16'h0068, "status_full_ovf");
    for (int i = 0; i < 8; i++) rdchk(1'b0, 2'd0, 16'h00A0 + 16'(i), "pop_a_seq");
    rdchk(1'b0, 2'd0, 16'h0000, "pop_empty_zero");
    rdchk(1'b0, 2'd1, 16'h00D0, "status_ovf_udf");
    wr(1'b0, 2'd2, 16'h0002);
    rdchk(1'b0, 2'd1, 16'h0010, "status_flags_cleared");

    // Pointer wrap with order preserved
    for (int i = 0; i < 5; i++) wr(1'b0, 2'd0, 16'h00B0 + 16'(i));
    for (int i = 0; i < 5; i++) rdchk(1'b0, 2'd0, 16'h00B0 + 16'(i), "pop_b_seq");
    for (int i = 0; i < 6; i++) wr(1'b0, 2'd0, 16'h00C0 + 16'(i));
    rdchk(1'b0, 2'd1, 16'h0006, "status_cnt6_wrapped");
    for (int i = 0; i < 3; i++) rdchk(1'b0, 2'd0, 16'h00C0 + 16'(i), "pop_c_seq");
    for (int i = 0; i < 6; i++) wr(1'b0, 2'd0, 16'h00D0 + 16'(i));
    rdchk(1'b0, 2'd1, 16'h0068, "status_refull_ovf");
    wr(1'b0, 2'd2, 16'h0003);
    chk("nempty_after_flush", {31'b0, ne0}, 32'd0);
    rdchk(1'b0, 2'd1, 16'h0010, "status_flush_clear");

    // Wait states: PREADY low for 3 access cycles, push only at commit
    xfer(1'b1, 2'd0, 1'b1, 16'h5A5A, r, w, n);
    chk("ws3_write_waits", w, 3);
    chk("ws3_no_early_push", {31'b0, n}, 32'd0);
    chk("ws3_nempty_commit", {31'b0, ne3}, 32'd1);
    xfer(1'b1, 2'd0, 1'b0, 16'h0, r, w, n);
    chk("ws3_pop_data", {16'b0, r}, 32'h5A5A);
    chk("ws3_read_waits", w, 3);
    wr(1'b1, 2'd0, 16'h7777);
    rdchk(1'b1, 2'd1, 16'h0001, "ws3_status_cnt1");

    // Async reset in the completing access cycle: no commit may survive
    paddr   = 16'h0000;
    pwrite  = 1'b1;
    pwdata  = 16'h9999;
    psel3   = 1'b1;
    penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ws3_ready_before_reset", {31'b0, rdy3}, 32'd1);
    reset = 1'b0;
    #1;
    chk("async_rst_pready", {31'b0, rdy3}, 32'd0);
    chk("async_rst_prdata", {16'b0, prd3}, 32'd0);
    chk("async_rst_nempty", {31'b0, ne3}, 32'd0);
    psel3   = 1'b0;
    penable = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    rdchk(1'b1, 2'd1, 16'h0010, "post_rst_status_empty");
    wr(1'b1, 2'd0, 16'h4242);
    rdchk(1'b1, 2'd1, 16'h0001, "post_rst_status_cnt1");
    rdchk(1'b1, 2'd0, 16'h4242, "post_rst_pop");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_mbox_slave.md
Name: apb_mbox_slave

Overview:
- APB responder (slave) on the far side of the core-to-slave interconnect.
- Exposes a hardware mailbox FIFO through which cores pass words to one another: a write to DATA pushes, a read from DATA pops.
- Provides a status register, sticky overflow/underflow flags, and a programmable fixed wait-state count.
- Drives a level not-empty output used as a doorbell interrupt.

Parameters:
- BUS_WIDTH, 16, PADDR width.
- DATA_WIDTH, 16, PWDATA/PRDATA and FIFO word width.
- DEPTH, 8, FIFO entries; must be a power of two, 2..256.
- WAIT_STATES, 0, access-phase cycles with PREADY low before completion; 0..15.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- S_PADDR  in  BUS_WIDTH  address; only [1:0] is decoded.
- S_PWRITE  in  1  1 = write, 0 = read.
- S_PSELx  in  1  slave select from the interconnect decoder.
- S_PENABLE  in  1  access-phase strobe.
- S_PWDATA  in  DATA_WIDTH  write data.
- S_PRDATA  out  DATA_WIDTH  read data; valid only while S_PREADY=1, otherwise 0.
- S_PREADY  out  1  transfer completion.
- mbox_nempty  out  1  level high while the FIFO count is nonzero.

Behaviour:
- Reset (reset=0, async): FIFO empty, count=0, pointers=0, ovf=0, udf=0, FSM=IDLE, wait counter=0. S_PREADY=0, S_PRDATA=0, mbox_nempty=0.
- Register map (PADDR[1:0]):
  - 0 DATA: write pushes PWDATA; read pops and returns the head word.
  - 1 STATUS: read-only = {zero-pad, udf, ovf, full, empty, count}, with count at [CW-1:0], CW=clog2(DEPTH)+1. Writes are ignored.
  - 2 CTRL: write bit0=1 flushes the FIFO; bit1=1 clears ovf and udf. Reads return 0.
  - 3: reserved; reads return 0, writes are ignored. Still completes with normal wait states.
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS on an edge with PSELx=1, PENABLE=0 (setup phase); wait counter loads WAIT_STATES.
  - In ACCESS with PSELx & PENABLE, the counter decrements each edge while nonzero.
  - S_PREADY = (state==ACCESS) & PSELx & PENABLE & (wcnt==0), decoded from registered state.
  - Transfer latency: setup + 1 + WAIT_STATES cycles. WAIT_STATES=0 completes in the first access cycle.
- Commit point: the rising edge where PSELx & PENABLE & S_PREADY. The side effect (push/pop/flush/clear) happens there and FSM returns to IDLE. This permits back-to-back transfers: the next setup phase is in the following cycle.
- Read data: combinational from the head entry or status while S_PREADY=1. Status reflects the pre-commit state.
- Push when full: data dropped, count unchanged, ovf set (sticky).
- Pop when empty: returns 0, pointers unchanged, udf set (sticky).
- Simultaneous events in one CTRL write: flush and flag-clear both apply. The flags are cleared after the flush, so the result is empty with ovf=udf=0.
- Abort: PSELx dropped while in ACCESS before completion -> FSM returns to IDLE, no side effect, counter reloads on the next setup.
- Pointer/count arithmetic:
  - Read/write pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is CW bits; full = (count==DEPTH), empty = (count==0).
- mbox_nempty is registered; it is updated at the same edge as count.

Decomposition:
- Shared package/header: register offsets MBOX_REG_DATA=0, STATUS=1, CTRL=2; CTRL bit positions FLUSH=0, CLRFLG=1; STATUS bit layout.
- One sub-module, mbox_fifo (sync FIFO: push/pop/flush, dout, count, full, empty), with the same async active-low reset.
- The APB FSM and register decode live in apb_mbox_slave.

Test Plan:
- Reset, then read STATUS (WAIT_STATES=0) -> PREADY in the first access cycle; PRDATA = count 0, empty=1, full=0, ovf=0, udf=0; mbox_nempty=0.
- Write DATA 0x1111, 0x2222, 0x3333 back-to-back -> STATUS count=3, mbox_nempty=1. Three DATA reads return 0x1111, 0x2222, 0x3333, then empty=1.
- DEPTH=8: push 9 words 0xA0..0xA8 -> full=1, ovf=1, count=8. Pop 8 returns 0xA0..0xA7. A 9th pop returns 0 with udf=1. Write CTRL=0x2 -> ovf=udf=0.
- WAIT_STATES=3: write DATA -> PREADY low for exactly 3 access cycles and high on the 4th; push occurs only at the completing edge.
- Push 5 words, then wrap: pop 5 and push 6 more -> pointers wrap and data order is preserved. Write CTRL=0x3 -> count=0, flags clear, mbox_nempty=0 next cycle.
- Assert reset low asynchronously mid-ACCESS (WAIT_STATES=3) -> PREADY=0 immediately, FIFO empty. After release the next transfer completes normally, with no stale commit.
